// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the async-FIFO read-side logic.
//   pkt_cnt_w(ratio) : width of a lane-count field able to hold 0..ratio
//   out_w(w, ratio)  : width of a packed output word (w * ratio)
//   DEF_*            : default geometry (8-bit entries, 4 lanes)
//   lane_idx_t       : lane index for the default geometry
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_RATIO = 4;
  localparam int DEF_OUT_W = DEF_WIDTH * DEF_RATIO;

  function automatic int pkt_cnt_w(input int ratio);
    return $clog2(ratio + 1);
  endfunction

  function automatic int out_w(input int width, input int ratio);
    return width * ratio;
  endfunction

  typedef logic [$clog2(DEF_RATIO)-1:0] lane_idx_t;

endpackage

// File: rtl/fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer
// Drains WIDTH-bit entries from the read side of an async FIFO and packs RATIO
// consecutive entries into one wide word (lane 0 = oldest entry). A flush
// request emits a partially filled word so end-of-burst data is not stranded.
//
// Ports
//   rclk      in   read-domain clock, rising edge
//   rrst      in   synchronous active-high reset
//   rempty    in   FIFO empty flag
//   rinc      out  FIFO read request; rdata valid the following cycle
//   rdata     in   FIFO read data
//   flush     in   single-cycle request to emit the current partial word
//   out_valid out  out_data / out_cnt valid
//   out_ready in   downstream accepts the word
//   out_data  out  packed word, WIDTH*RATIO bits
//   out_cnt   out  number of valid lanes, 1..RATIO
// -----------------------------------------------------------------------------
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
) (
  input  logic                          rclk,
  input  logic                          rrst,
  input  logic                          rempty,
  output logic                          rinc,
  input  logic [WIDTH-1:0]              rdata,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH*RATIO-1:0]        out_data,
  output logic [pkt_cnt_w(RATIO)-1:0]   out_cnt
);

  localparam int CW    = pkt_cnt_w(RATIO);
  localparam int OUT_W = out_w(WIDTH, RATIO);

  // State
  logic [WIDTH-1:0] r_acc [RATIO];
  logic [CW-1:0]    r_cnt;
  logic             r_pend;
  logic             r_flush_req;
  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_data;
  logic [CW-1:0]    r_out_cnt;

  // Combinational helpers
  logic             w_out_free;
  logic             w_xfer_full;
  logic [CW-1:0]    w_cnt_eff;
  logic [CW:0]      w_inflight;
  logic             w_rinc;
  logic             w_flush_emit;
  logic             w_flush_drop;
  logic [CW-1:0]    w_cnt_next;
  logic [OUT_W-1:0] w_acc_flat;
  logic [OUT_W-1:0] w_flush_flat;

  assign w_out_free  = !r_out_valid || out_ready;
  assign w_xfer_full = (r_cnt == CW'(RATIO)) && w_out_free;
  // A full accumulator that drains this cycle frees every lane immediately,
  // so the landing read and the issue check both see an empty accumulator.
  assign w_cnt_eff   = w_xfer_full ? '0 : r_cnt;
  // One extra bit so entries-held plus read-in-flight cannot wrap.
  assign w_inflight  = {1'b0, w_cnt_eff} + (CW+1)'(r_pend);

  assign w_rinc = !rrst && !rempty && !r_flush_req && (w_inflight < (CW+1)'(RATIO));
  assign rinc   = w_rinc;

  // A flush waits for the in-flight read to land before deciding.
  assign w_flush_emit = r_flush_req && !r_pend && (r_cnt != '0) &&
                        (r_cnt < CW'(RATIO)) && w_out_free;
  assign w_flush_drop = r_flush_req && !r_pend && (r_cnt == '0);

  always_comb begin
    w_cnt_next = w_cnt_eff;
    if (w_flush_emit) begin
      w_cnt_next = '0;
    end else if (r_pend) begin
      w_cnt_next = w_cnt_eff + CW'(1);
    end
  end

  // Flat views of the accumulator: full word, and partial word with lanes at
  // or above the fill count forced to zero (stale data from earlier words).
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    assign w_acc_flat[gi*WIDTH +: WIDTH]   = r_acc[gi];
    assign w_flush_flat[gi*WIDTH +: WIDTH] = (CW'(gi) < r_cnt) ? r_acc[gi] : '0;
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      for (int i = 0; i < RATIO; i++) begin
        r_acc[i] <= '0;
      end
      r_cnt       <= '0;
      r_pend      <= 1'b0;
      r_flush_req <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_cnt   <= '0;
    end else begin
      r_pend <= w_rinc;
      r_cnt  <= w_cnt_next;

      for (int i = 0; i < RATIO; i++) begin
        if (r_pend && (w_cnt_eff == CW'(i))) begin
          r_acc[i] <= rdata;
        end
      end

      // A new flush request wins over clearing so back-to-back flushes merge.
      if (flush) begin
        r_flush_req <= 1'b1;
      end else if (w_flush_emit || w_flush_drop) begin
        r_flush_req <= 1'b0;
      end

      if (w_xfer_full) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_acc_flat;
        r_out_cnt   <= CW'(RATIO);
      end else if (w_flush_emit) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_flush_flat;
        r_out_cnt   <= r_cnt;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_cnt   = r_out_cnt;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_packer
// Scoreboard bench: directed stimulus pushes expected words into a queue, a
// negedge monitor pops and compares every accepted output word, checks that
// held words stay stable and that rinc never fires while the FIFO is empty.
// -----------------------------------------------------------------------------
module tb_fifo_rd_packer;

  localparam int WIDTH = 8;
  localparam int RATIO = 4;
  localparam int OUT_W = 32;
  localparam int CW    = 3;

  logic             clk = 1'b0;
  logic             rrst;
  logic             rempty;
  logic             rinc;
  logic [WIDTH-1:0] rdata = '0;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [CW-1:0]    out_cnt;

  always #5 clk = ~clk;

  fifo_rd_packer #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
    .rclk      (clk),
    .rrst      (rrst),
    .rempty    (rempty),
    .rinc      (rinc),
    .rdata     (rdata),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt)
  );

  // FIFO read-side model: rdata appears one clock after rinc.
  logic [7:0] fifo_mem [64];
  int         push_cnt = 0;
  int         pop_cnt  = 0;
  logic       hold_empty;

  assign rempty = hold_empty || (push_cnt == pop_cnt);

  always @(posedge clk) begin
    if (rrst) begin
      pop_cnt <= push_cnt;
    end else if (rinc) begin
      rdata   <= fifo_mem[pop_cnt % 64];
      pop_cnt <= pop_cnt + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard
  typedef struct {
    logic [OUT_W-1:0] data;
    logic [CW-1:0]    cnt;
    int               gap;   // cycles since previous accepted word, -1 = any
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int mon_checks = 0;
  int mon_errors = 0;
  int dir_checks = 0;
  int dir_errors = 0;

  int               last_acc = -1;
  logic             hold_armed = 1'b0;
  logic [OUT_W-1:0] hold_data;
  logic [CW-1:0]    hold_cnt;

  always @(negedge clk) begin
    if (!rrst) begin
      if (rempty) begin
        mon_checks++;
        if (rinc) begin
          mon_errors++;
          $display("FAIL rinc_while_empty cyc=%0d: rinc=%b required 0", cyc, rinc);
        end
      end
      if (hold_armed && out_valid) begin
        mon_checks++;
        if (out_data !== hold_data || out_cnt !== hold_cnt) begin
          mon_errors++;
          $display("FAIL hold_stable cyc=%0d: got %h/%0d required %h/%0d",
                   cyc, out_data, out_cnt, hold_data, hold_cnt);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          mon_checks++;
          mon_errors++;
          $display("FAIL unexpected_word cyc=%0d: got %h cnt=%0d required none",
                   cyc, out_data, out_cnt);
        end else begin
          mon_e = exp_q.pop_front();
          mon_checks++;
          if (out_data !== mon_e.data) begin
            mon_errors++;
            $display("FAIL word_data cyc=%0d: got %h required %h", cyc, out_data, mon_e.data);
          end
          mon_checks++;
          if (out_cnt !== mon_e.cnt) begin
            mon_errors++;
            $display("FAIL word_cnt cyc=%0d: got %0d required %0d", cyc, out_cnt, mon_e.cnt);
          end
          if (mon_e.gap >= 0) begin
            mon_checks++;
            if (cyc - last_acc != mon_e.gap) begin
              mon_errors++;
              $display("FAIL word_gap cyc=%0d: got %0d required %0d",
                       cyc, cyc - last_acc, mon_e.gap);
            end
          end
          $display("word %h cnt=%0d accepted at cyc %0d", out_data, out_cnt, cyc);
        end
        last_acc = cyc;
      end
      hold_armed = out_valid && !out_ready;
      hold_data  = out_data;
      hold_cnt   = out_cnt;
    end else begin
      hold_armed = 1'b0;
    end
  end

  // Directed stimulus helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [OUT_W-1:0] act,
                     input logic [OUT_W-1:0] exp);
    dir_checks++;
    if (act !== exp) begin
      dir_errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    fifo_mem[push_cnt % 64] = v;
    push_cnt++;
  endtask

  task automatic expect_word(input logic [OUT_W-1:0] d, input logic [CW-1:0] c,
                             input int gap);
    exp_t e;
    e.data = d;
    e.cnt  = c;
    e.gap  = gap;
    exp_q.push_back(e);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    dir_checks++;
    if (exp_q.size() != 0) begin
      dir_errors++;
      $display("FAIL %s_timeout: got %0d words pending required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

  int start;
  int n;

  initial begin
    rrst       = 1'b1;
    hold_empty = 1'b1;
    flush      = 1'b0;
    out_ready  = 1'b1;
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_cnt",   out_cnt,   0);
    chk("rst_out_data",  out_data,  0);
    rrst = 1'b0;

    // 1: idle with an empty FIFO
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_rinc",      rinc,      0);
      chk("idle_out_valid", out_valid, 0);
      chk("idle_out_cnt",   out_cnt,   0);
    end

    // 2: two full words, free-running consumer
    for (int i = 1; i <= 8; i++) push(8'(i * 8'h11));
    expect_word(32'h44332211, 3'd4, -1);
    expect_word(32'h88776655, 3'd4, 5);
    hold_empty = 1'b0;
    wait_drain("t2", 40);

    // 3: consumer stalled for 20 cycles
    out_ready = 1'b0;
    start = pop_cnt;
    for (int i = 1; i <= 8; i++) push(8'(i * 8'h11));
    push(8'h99); push(8'hAA); push(8'hBB); push(8'hCC);
    repeat (20) tick();
    chk("stall_reads",     pop_cnt - start, 8);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_out_data",  out_data, 32'h44332211);
    expect_word(32'h44332211, 3'd4, -1);
    expect_word(32'h88776655, 3'd4, 1);
    expect_word(32'hCCBBAA99, 3'd4, 5);
    out_ready = 1'b1;
    wait_drain("t3", 40);

    // 4: partial word via flush, then an empty flush
    push(8'hA1); push(8'hA2); push(8'hA3);
    repeat (8) tick();
    chk("partial_no_word", out_valid, 0);
    expect_word(32'h00A3A2A1, 3'd3, -1);
    pulse_flush();
    wait_drain("t4", 20);
    pulse_flush();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("empty_flush_no_word", out_valid, 0);
    end

    // 5: flush lands in the cycle of the 3rd read
    hold_empty = 1'b1;
    push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4); push(8'hB5);
    start = pop_cnt;
    expect_word(32'h00B3B2B1, 3'd3, -1);
    hold_empty = 1'b0;      // c0: first read
    tick();                 // c1: second read
    tick();                 // c2: third read
    chk("flush_cycle_rinc", rinc, 1);
    pulse_flush();          // c3
    chk("no_4th_read_a", rinc, 0);
    tick();                 // c4
    chk("no_4th_read_b", rinc, 0);
    chk("reads_before_emit", pop_cnt - start, 3);
    wait_drain("t5a", 20);
    repeat (6) tick();
    expect_word(32'h0000B5B4, 3'd2, -1);
    pulse_flush();
    wait_drain("t5b", 20);

    // 6: reset with cnt=2, pend=1, out_valid=1
    out_ready  = 1'b0;
    hold_empty = 1'b1;
    for (int i = 1; i <= 8; i++) push(8'(i));
    start = pop_cnt;
    hold_empty = 1'b0;
    n = 0;
    while (pop_cnt - start != 7 && n < 30) begin
      tick();
      n++;
    end
    chk("mid_reads", pop_cnt - start, 7);
    chk("mid_out_valid", out_valid, 1);
    rrst = 1'b1;
    #1;
    chk("rinc_gated_by_rrst", rinc, 0);
    tick();
    rrst = 1'b0;
    #1;
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_out_cnt",   out_cnt,   0);
    chk("post_rst_rinc",      rinc,      0);
    out_ready = 1'b1;
    push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
    expect_word(32'hD4D3D2D1, 3'd4, -1);
    wait_drain("t6", 40);
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             mon_checks + dir_checks, mon_errors + dir_errors);
    $finish;
  end

endmodule
